// File: rtl/remote_key_pkg.sv
// Shared constants for the IR remote key event buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package remote_key_pkg;

    // Avalon word addresses
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;

    // DATA register
    localparam int DATA_VALID_BIT = 31;

    // STATUS register ([7:0] holds the FIFO count)
    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_HELD_BIT  = 9;
    localparam int STAT_EMPTY_BIT = 10;

    // STATUS write command bits
    localparam int CMD_FLUSH_BIT   = 0;
    localparam int CMD_CLR_OVF_BIT = 1;

    // CTRL register
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_REP_ACC_BIT = 1;

    // One queued key event
    typedef struct packed {
        logic       rep;
        logic [7:0] code;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/remote_key_fifo.sv
// Single-clock FIFO with first-word-fall-through output and synchronous flush.
// Latency: push visible on dout/count one cycle later; pop advances dout next cycle.
// Backpressure: push while full is dropped unless a pop lands in the same cycle; pop while empty ignored.
module remote_key_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer/count update; a pop frees the slot a same-cycle push needs, flush overrides both
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only slots behind the pointers are ever read out
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/remote_key_buf.sv
// IR remote key event buffer: syncs receiver strobes, tracks held key, queues events for Avalon-MM reads.
// Latency: strobe edge to FIFO push 3 sys_clk; avl_readdata 1 cycle after avl_read; irq 1 cycle behind FIFO.
// Backpressure: none upstream; events pushed into a full FIFO are dropped and flagged in sticky overflow.
module remote_key_buf
    import remote_key_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int HOLD_TIMEOUT = 6_000_000,
    parameter int REPEAT_DIV   = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        rcv_data_en,
    input  logic        rcv_repeat_en,
    input  logic [7:0]  rcv_data,
    input  logic [2:0]  avl_address,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    input  logic        avl_read,
    output logic [31:0] avl_readdata,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);
    localparam int RW = $clog2(REPEAT_DIV + 1);

    logic [2:0]    dat_sync_q, dat_sync_d;
    logic [2:0]    rep_sync_q, rep_sync_d;
    logic          key_held_q, key_held_d;
    logic [7:0]    last_code_q, last_code_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic          rep_acc_q, rep_acc_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;

    logic          data_edge, rep_edge;
    logic          push_vld;
    evt_t          push_dat;
    evt_t          fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          pop_vld, flush_vld, clr_ovf;
    logic [31:0]   status_dat;
    logic          unused_wdata;

    assign unused_wdata = ^avl_writedata[31:2];
    assign avl_readdata = rdata_q;
    assign irq          = irq_q;

    // Synchroniser chains; bit 2 is the previous sample used for rising-edge detect
    always_comb begin
        dat_sync_d = {dat_sync_q[1:0], rcv_data_en};
        rep_sync_d = {rep_sync_q[1:0], rcv_repeat_en};
        data_edge  = dat_sync_q[1] & ~dat_sync_q[2];
        rep_edge   = rep_sync_q[1] & ~rep_sync_q[2] & ~data_edge;
    end

    // Key tracker: frames always push, repeats of a held key push every REPEAT_DIV-th one
    always_comb begin
        push_vld    = 1'b0;
        push_dat    = '{rep: 1'b0, code: rcv_data};
        key_held_d  = key_held_q;
        last_code_d = last_code_q;
        rep_cnt_d   = rep_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        if (data_edge) begin
            push_vld    = 1'b1;
            last_code_d = rcv_data;
            key_held_d  = 1'b1;
            rep_cnt_d   = '0;
            tmo_cnt_d   = '0;
        end else if (rep_edge && key_held_q) begin
            tmo_cnt_d = '0;
            if (rep_acc_q) begin
                if (rep_cnt_q == RW'(REPEAT_DIV - 1)) begin
                    push_vld  = 1'b1;
                    push_dat  = '{rep: 1'b1, code: last_code_q};
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
            end
        end else if (key_held_q) begin
            if (tmo_cnt_q == TW'(HOLD_TIMEOUT - 1)) begin
                key_held_d = 1'b0;
                tmo_cnt_d  = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
    end

    // Avalon register file, read mux, overflow flag and irq
    always_comb begin
        pop_vld   = avl_read && (avl_address == ADDR_DATA) && !fifo_empty;
        flush_vld = avl_write && (avl_address == ADDR_STATUS) && avl_writedata[CMD_FLUSH_BIT];
        clr_ovf   = avl_write && (avl_address == ADDR_STATUS) && avl_writedata[CMD_CLR_OVF_BIT];

        status_dat                 = '0;
        status_dat[7:0]            = 8'(fifo_count);
        status_dat[STAT_OVF_BIT]   = ovf_q;
        status_dat[STAT_HELD_BIT]  = key_held_q;
        status_dat[STAT_EMPTY_BIT] = fifo_empty;

        irq_en_d  = irq_en_q;
        rep_acc_d = rep_acc_q;
        if (avl_write && (avl_address == ADDR_CTRL)) begin
            irq_en_d  = avl_writedata[CTRL_IRQ_EN_BIT];
            rep_acc_d = avl_writedata[CTRL_REP_ACC_BIT];
        end

        // A new drop in the same cycle as a clear keeps the flag set
        ovf_d = (ovf_q & ~clr_ovf) | (push_vld & fifo_full & ~pop_vld & ~flush_vld);

        rdata_d = rdata_q;
        if (avl_read) begin
            rdata_d = '0;
            case (avl_address)
                ADDR_DATA: begin
                    if (!fifo_empty) begin
                        rdata_d[DATA_VALID_BIT] = 1'b1;
                        rdata_d[EVT_W-1:0]      = fifo_dout;
                    end
                end
                ADDR_STATUS: rdata_d = status_dat;
                ADDR_CTRL: begin
                    rdata_d[CTRL_IRQ_EN_BIT]  = irq_en_q;
                    rdata_d[CTRL_REP_ACC_BIT] = rep_acc_q;
                end
                default: rdata_d = '0;
            endcase
        end

        irq_d = irq_en_q & ~fifo_empty;
    end

    // State registers; synchronisers reset high so a strobe already high at reset release is not seen as an edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dat_sync_q  <= '1;
            rep_sync_q  <= '1;
            key_held_q  <= 1'b0;
            last_code_q <= '0;
            rep_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            rep_acc_q   <= 1'b1;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            dat_sync_q  <= dat_sync_d;
            rep_sync_q  <= rep_sync_d;
            key_held_q  <= key_held_d;
            last_code_q <= last_code_d;
            rep_cnt_q   <= rep_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ovf_q       <= ovf_d;
            irq_en_q    <= irq_en_d;
            rep_acc_q   <= rep_acc_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    remote_key_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push_vld),
        .pop   (pop_vld),
        .flush (flush_vld),
        .din   (push_dat),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_remote_key_buf.sv
// Bench for remote_key_buf against a queue-based event model.
// Latency: n/a.
// Backpressure: n/a.
module tb_remote_key_buf;

    localparam int DEPTH = 8;
    localparam int HOLD  = 200;
    localparam int DIV   = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rcv_data_en = 1'b0;
    logic        rcv_repeat_en = 1'b0;
    logic [7:0]  rcv_data = '0;
    logic [2:0]  avl_address = '0;
    logic        avl_write = 1'b0;
    logic [31:0] avl_writedata = '0;
    logic        avl_read = 1'b0;
    logic [31:0] avl_readdata;
    logic        irq;

    always #5 sys_clk = ~sys_clk;

    remote_key_buf #(
        .FIFO_DEPTH   (DEPTH),
        .HOLD_TIMEOUT (HOLD),
        .REPEAT_DIV   (DIV)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .rcv_data_en   (rcv_data_en),
        .rcv_repeat_en (rcv_repeat_en),
        .rcv_data      (rcv_data),
        .avl_address   (avl_address),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_read      (avl_read),
        .avl_readdata  (avl_readdata),
        .irq           (irq)
    );

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Reference model: event queue plus key-held window measured in cycles
    logic [8:0]  mq[$];
    bit          m_ovf, m_held, m_irq_en, m_rep_acc;
    logic [7:0]  m_last;
    int          m_repn;
    int unsigned m_act;

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0; m_held = 0; m_irq_en = 0; m_rep_acc = 1;
        m_last = '0; m_repn = 0; m_act = cyc;
    endfunction

    function automatic bit m_held_now();
        return m_held && ((cyc - m_act) < HOLD);
    endfunction

    function automatic void m_push(logic [8:0] e);
        if (mq.size() == DEPTH) m_ovf = 1;
        else mq.push_back(e);
    endfunction

    function automatic void m_strobe(bit is_rep, logic [7:0] code);
        if (!is_rep) begin
            m_push({1'b0, code});
            m_last = code; m_held = 1; m_repn = 0; m_act = cyc;
        end else if (m_held_now()) begin
            m_act = cyc;
            if (m_rep_acc) begin
                m_repn++;
                if (m_repn == DIV) begin
                    m_repn = 0;
                    m_push({1'b1, m_last});
                end
            end
        end
    endfunction

    function automatic logic [31:0] m_status();
        return {21'b0, mq.size() == 0, m_held_now(), m_ovf, 8'(mq.size())};
    endfunction

    function automatic logic [31:0] m_pop_word();
        logic [8:0] e;
        if (mq.size() == 0) return 32'h0;
        e = mq.pop_front();
        return {1'b1, 22'b0, e};
    endfunction

    // Stimulus helpers
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_reset();
    endtask

    task automatic strobe(input bit is_rep, input logic [7:0] code);
        @(negedge sys_clk);
        rcv_data = code;
        if (is_rep) rcv_repeat_en = 1'b1;
        else        rcv_data_en   = 1'b1;
        m_strobe(is_rep, code);
        repeat (4) @(negedge sys_clk);
        rcv_data_en   = 1'b0;
        rcv_repeat_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic avl_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        avl_address = a;
        avl_read    = 1'b1;
        @(negedge sys_clk);
        avl_read = 1'b0;
        d = avl_readdata;
    endtask

    task automatic avl_wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge sys_clk);
        avl_address   = a;
        avl_writedata = v;
        avl_write     = 1'b1;
        @(negedge sys_clk);
        avl_write = 1'b0;
    endtask

    // Keep status reads and repeats away from the held-timeout boundary
    task automatic guard();
        int unsigned el;
        el = cyc - m_act;
        if (m_held && (el + 40 > HOLD) && (el < HOLD + 40)) repeat (80) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        @(negedge sys_clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b want=0", irq); end
        total++; if (avl_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", avl_readdata); end
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL reset_status got=%h want=%h", d, m_status()); end
        avl_rd(3'd0, d);
        total++; if (d !== m_pop_word()) begin bad++; $display("FAIL reset_data got=%h want=0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d, e;
        strobe(1'b0, 8'h45);
        avl_wr(3'd2, 32'h3);
        m_irq_en = 1; m_rep_acc = 1;
        repeat (2) @(negedge sys_clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL single_irq_on got=%0b want=1", irq); end
        avl_rd(3'd0, d);
        e = m_pop_word();
        total++; if (d !== e) begin bad++; $display("FAIL single_data got=%h want=%h", d, e); end
        repeat (2) @(negedge sys_clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL single_irq_off got=%0b want=0", irq); end
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL single_status got=%h want=%h", d, m_status()); end
    endtask

    task automatic test_repeat_div();
        logic [31:0] d, e;
        strobe(1'b0, 8'h16);
        for (int i = 0; i < 8; i++) begin
            repeat (20) @(negedge sys_clk);
            guard();
            strobe(1'b1, 8'h00);
        end
        guard();
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL repdiv_status got=%h want=%h", d, m_status()); end
        for (int i = 0; i < 3; i++) begin
            avl_rd(3'd0, d);
            e = m_pop_word();
            total++; if (d !== e) begin bad++; $display("FAIL repdiv_data%0d got=%h want=%h", i, d, e); end
        end
    endtask

    task automatic test_orphan_repeat();
        logic [31:0] d, e;
        do_reset();
        strobe(1'b1, 8'($urandom));
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL orphan_status got=%h want=%h", d, m_status()); end
        strobe(1'b0, 8'($urandom));
        avl_rd(3'd0, d);
        e = m_pop_word();
        total++; if (d !== e) begin bad++; $display("FAIL orphan_frame got=%h want=%h", d, e); end
        repeat (HOLD + 40) @(negedge sys_clk);
        strobe(1'b1, 8'h00);
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL expired_status got=%h want=%h", d, m_status()); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        for (int i = 0; i < 10; i++) strobe(1'b0, 8'($urandom));
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL ovf_status got=%h want=%h", d, m_status()); end
        avl_rd(3'd0, d);
        e = m_pop_word();
        total++; if (d !== e) begin bad++; $display("FAIL ovf_first got=%h want=%h", d, e); end
        avl_wr(3'd1, 32'h2);
        m_ovf = 0;
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL ovf_clear got=%h want=%h", d, m_status()); end
        avl_wr(3'd1, 32'h1);
        mq.delete();
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL flush_status got=%h want=%h", d, m_status()); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d, e;
        logic [7:0]  c;
        for (int i = 0; i < DEPTH; i++) strobe(1'b0, 8'($urandom));
        // Push lands three edges after the strobe rises; the read is lined up to pop on that same edge
        c = 8'($urandom);
        @(negedge sys_clk);
        rcv_data = c; rcv_data_en = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        avl_address = 3'd0; avl_read = 1'b1;
        @(negedge sys_clk);
        avl_read = 1'b0;
        d = avl_readdata;
        e = m_pop_word();
        m_strobe(1'b0, c);
        repeat (3) @(negedge sys_clk);
        rcv_data_en = 1'b0;
        repeat (4) @(negedge sys_clk);
        total++; if (d !== e) begin bad++; $display("FAIL fullpp_data got=%h want=%h", d, e); end
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL fullpp_status got=%h want=%h", d, m_status()); end
        for (int i = 0; i < DEPTH; i++) begin
            avl_rd(3'd0, d);
            e = m_pop_word();
            total++; if (d !== e) begin bad++; $display("FAIL fullpp_drain%0d got=%h want=%h", i, d, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        strobe(1'b0, 8'h5a);
        @(negedge sys_clk);
        rcv_data = 8'($urandom); rcv_data_en = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_reset();
        repeat (3) @(negedge sys_clk);
        rcv_data_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%0b want=0", irq); end
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL rstmid_status got=%h want=%h", d, m_status()); end
        avl_rd(3'd2, d);
        e = {30'b0, m_rep_acc, m_irq_en};
        total++; if (d !== e) begin bad++; $display("FAIL rstmid_ctrl got=%h want=%h", d, e); end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        bit          ra, ie;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: strobe(1'b0, 8'($urandom));
                3, 4, 5: begin guard(); strobe(1'b1, 8'($urandom)); end
                6, 7: begin
                    avl_rd(3'd0, d);
                    e = m_pop_word();
                    total++; if (d !== e) begin bad++; $display("FAIL rand_data%0d got=%h want=%h", i, d, e); end
                end
                8: begin
                    ra = 1'($urandom); ie = 1'($urandom);
                    avl_wr(3'd2, {30'b0, ra, ie});
                    m_rep_acc = ra; m_irq_en = ie;
                end
                default: repeat (HOLD + 40) @(negedge sys_clk);
            endcase
            repeat ($urandom_range(0, 15)) @(negedge sys_clk);
        end
        guard();
        avl_rd(3'd1, d);
        total++; if (d !== m_status()) begin bad++; $display("FAIL rand_status got=%h want=%h", d, m_status()); end
        repeat (2) @(negedge sys_clk);
        total++; if (irq !== (m_irq_en && mq.size() != 0)) begin
            bad++; $display("FAIL rand_irq got=%0b want=%0b", irq, m_irq_en && mq.size() != 0);
        end
        while (mq.size() != 0) begin
            avl_rd(3'd0, d);
            e = m_pop_word();
            total++; if (d !== e) begin bad++; $display("FAIL rand_drain got=%h want=%h", d, e); end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_repeat_div();
        test_orphan_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remote_key_buf.md
Name: remote_key_buf

Overview:
Downstream consumer of the IR NEC receiver stage. It takes the receiver's decoded-frame and repeat-code strobes (level pulses from the slow 8 kHz domain), synchronises and edge-detects them in sys_clk, and tracks key-held state with a release timeout. Events go into a small FIFO that Nios II reads through an Avalon-MM slave. Key presses are therefore not lost between CPU polls, and the block raises an interrupt while the FIFO is non-empty.

Parameters:
FIFO_DEPTH, 8, event FIFO depth; power of 2, 2..64
HOLD_TIMEOUT, 6_000_000, sys_clk cycles without frame/repeat before key is released (120 ms at 50 MHz)
REPEAT_DIV, 4, push every Nth repeat code of a held key; 1 = push every repeat

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
rcv_data_en  in  1  receiver frame-valid strobe; asynchronous to sys_clk, high >=2 sys_clk cycles
rcv_repeat_en  in  1  receiver repeat-code strobe; same timing as rcv_data_en
rcv_data  in  8  receiver control code; stable while rcv_data_en is high
avl_address  in  3  Avalon word address
avl_write  in  1  write request
avl_writedata  in  32  write data
avl_read  in  1  read request
avl_readdata  out  32  read data, registered
irq  out  1  interrupt, level-sensitive

Behaviour:
- Reset (sys_rst sampled high on a sys_clk edge) clears the following:
  - avl_readdata=0, irq=0
  - FIFO pointers and count = 0, overflow=0
  - key_held=0, last_code=0, rep_cnt=0, timeout counter=0
  - ctrl irq_en=0, rep_accept=1
- Reset mid-operation discards all queued events.
- Input path:
  - rcv_data_en and rcv_repeat_en each pass through a 2-FF synchroniser; a third FF gives rising-edge detect.
  - rcv_data is captured on the data rising edge.
  - Latency from input edge to event push: 3 cycles.
  - Data edge and repeat edge in the same cycle: data wins, repeat is ignored.
- Key tracker:
  - Data edge: push {rep=0, code}; last_code<=code; key_held<=1; rep_cnt<=0; timeout counter reloads.
  - Repeat edge with key_held=1 and rep_accept=1: timeout reloads; rep_cnt increments.
    - When rep_cnt reaches REPEAT_DIV-1, push {rep=1, last_code} and set rep_cnt<=0.
  - Repeat edge with key_held=0: ignored, no push. A repeat before any frame is dropped.
  - Repeat edge with rep_accept=0: timeout still reloads, no push.
  - Timeout counter reaching HOLD_TIMEOUT-1: key_held<=0 on the next edge. No event is pushed.
- FIFO entry is 9 bits: {rep, code[7:0]}.
  - Push while full: entry dropped, sticky overflow<=1.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full, so the push is not dropped.
  - Pop while empty: no effect.
- Register map (read data appears on avl_readdata the cycle after avl_read; one-cycle read latency):
  - addr 0 read DATA: {valid[31], 22'b0, rep[8], code[7:0]}.
    - valid=1 if the FIFO was non-empty; the entry is popped on the same cycle.
    - Empty: returns 0 and nothing is popped.
  - addr 1 read STATUS: [7:0]=count (zero-extended), [8]=overflow, [9]=key_held, [10]=empty.
  - addr 1 write: bit0=1 flushes the FIFO, bit1=1 clears overflow.
    - Flush wins over a simultaneous push.
    - A clear coinciding with a new overflow leaves overflow=1.
  - addr 2 read/write CTRL: [0]=irq_en, [1]=rep_accept.
  - Other addresses: reads return 0, writes are ignored.
  - avl_read and avl_write asserted together: both are serviced.
- irq is registered: irq_en & ~empty, one cycle behind the FIFO state.

Decomposition:
- Package remote_key_pkg holds:
  - address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2
  - STATUS/CTRL bit positions
  - event entry width (9)
- Sub-module remote_key_fifo: single-clock synchronous FIFO, parameterised WIDTH/DEPTH.
  - Ports: push, pop, flush, din, dout (first-word-fall-through), count, full, empty.
- The top level holds the synchronisers, key tracker, timeout counter and Avalon register logic.

Test Plan:
- Reset, then read addr1 -> 0x400 (empty). Read addr0 -> 0x0. irq=0.
- rcv_data=0x45, one data strobe; write CTRL=0x3 -> irq=1. Read addr0 -> 0x8000_0045. Then irq=0 and STATUS=0x600 (empty, key_held).
- Frame 0x16, then 8 repeat strobes 1 ms apart, REPEAT_DIV=4 -> FIFO count=3, reads 0x8000_0016, 0x8000_0116, 0x8000_0116.
- Repeat strobe with no prior frame, and a repeat strobe after HOLD_TIMEOUT expiry -> no push; STATUS[9]=0.
- 10 frames with no reads, FIFO_DEPTH=8 -> count=8, overflow=1, first entry is the first code. Write addr1=0x2 -> overflow=0. Write addr1=0x1 -> empty.
- FIFO full, read addr0 on the same cycle as a push -> count stays 8, overflow stays 0. Separately, assert sys_rst mid-strobe -> all state cleared and no spurious event after release.
